// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use, MDU busy, redirect and external stall arbitration
// Arbitrates stall/flush controls and tracks the multiply/divide unit occupancy.
module pipe_hazard_ctrl #(
   parameter int MDU_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_mdu_op,
   input  logic        id_mdu_rd,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rfwr,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        ext_stall,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idexe_stall,
   output logic        idexe_flush,
   output logic        exemem_stall,
   output logic        mdu_start,
   output logic        mdu_busy,
   output logic [15:0] stall_cycles
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [5:0] CNT_INIT = 6'(MDU_LAT - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic load_hz;
   logic mdu_hz;

   assign load_hz = ex_is_load & ex_rfwr & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
   assign mdu_hz  = (state_q == BUSY) & (id_mdu_op | id_mdu_rd);

   // Priority: external freeze, then redirect, then a bubble for either data hazard.
   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idexe_stall  = 1'b0;
      idexe_flush  = 1'b0;
      exemem_stall = 1'b0;
      mdu_start    = 1'b0;
      if (ext_stall) begin
         pc_stall     = 1'b1;
         ifid_stall   = 1'b1;
         idexe_stall  = 1'b1;
         exemem_stall = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idexe_flush = 1'b1;
      end else if (load_hz | mdu_hz) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idexe_flush = 1'b1;
      end else begin
         mdu_start = id_mdu_op & ~rst;
      end
   end

   // The countdown keeps running under ext_stall: the MDU is not frozen by memory waits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mdu_start) begin
         state_d = BUSY;
         cnt_d   = CNT_INIT;
      end else if (state_q == BUSY) begin
         if (cnt_q == 6'd1) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
         end else begin
            cnt_d = cnt_q - 6'd1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mdu_busy     = (state_q == BUSY);
   assign stall_cycles = stall_cnt_q;

endmodule
